// File: rtl/cache_mem_arbiter_pkg.sv
// Shared types for the cache-to-memory arbiter: FSM states and the
// memory request/data field widths that the cache controllers already use.
package cache_mem_arbiter_pkg;

  localparam int MEM_ADDR_W = 32;
  localparam int MEM_LINE_W = 128;

  typedef struct packed {
    logic                  valid;
    logic                  rw;
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_LINE_W-1:0] data;
  } mem_req_type;

  typedef struct packed {
    logic                  ready;
    logic [MEM_LINE_W-1:0] data;
  } mem_data_type;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/cache_mem_arbiter_rr_arbiter.sv
// Combinational round-robin picker: the first pending port after the last
// granted one (wrapping) becomes the owner.
module rr_arbiter #(
  parameter int NUM_PORTS = 2,
  parameter int IDX_W     = 1
) (
  input  logic [NUM_PORTS-1:0] pend,
  input  logic [IDX_W-1:0]     last_grant,
  output logic [IDX_W-1:0]     owner,
  output logic                 any
);

  logic [IDX_W-1:0] cand;

  // Scanning from last_grant+1 puts the most recently served port last.
  always_comb begin
    owner = '0;
    any   = 1'b0;
    cand  = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      cand = IDX_W'((int'(last_grant) + k) % NUM_PORTS);
      if (!any && pend[cand]) begin
        owner = cand;
        any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one line-wide memory port between several cache controllers, each
// with a 1-deep request slot, served one transaction at a time in round-robin order.
module cache_mem_arbiter
  import cache_mem_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = MEM_ADDR_W,
  parameter int LINE_W    = MEM_LINE_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PORTS-1:0]        req_valid,
  input  logic [NUM_PORTS-1:0]        req_rw,
  input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
  input  logic [NUM_PORTS*LINE_W-1:0] req_data,
  output logic [NUM_PORTS-1:0]        rsp_ready,
  output logic [LINE_W-1:0]           rsp_data,
  output logic [NUM_PORTS-1:0]        req_ovf,
  output logic                        mem_valid,
  output logic                        mem_rw,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [LINE_W-1:0]           mem_wdata,
  input  logic                        mem_ready,
  input  logic [LINE_W-1:0]           mem_rdata
);

  localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  arb_state_t           state, state_nxt;
  logic [NUM_PORTS-1:0] pend;
  logic [IDX_W-1:0]     owner, last_grant, rr_owner;
  logic                 rr_any;
  logic [NUM_PORTS-1:0] slot_rw;
  logic [ADDR_W-1:0]    slot_addr [NUM_PORTS];
  logic [LINE_W-1:0]    slot_data [NUM_PORTS];

  rr_arbiter #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_rr (
    .pend       (pend),
    .last_grant (last_grant),
    .owner      (rr_owner),
    .any        (rr_any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= '0;
      last_grant <= IDX_W'(NUM_PORTS - 1);
      pend       <= '0;
      req_ovf    <= '0;
      slot_rw    <= '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        slot_addr[i] <= '0;
        slot_data[i] <= '0;
      end
    end else begin
      state <= state_nxt;
      if (state == IDLE && rr_any)
        owner <= rr_owner;
      if (state == WAIT && mem_ready)
        last_grant <= owner;
      // A completing slot may be refilled on the same edge, so the
      // write-back/allocate pair of one cache never overflows.
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (req_valid[i] && (!pend[i] || rsp_ready[i])) begin
          pend[i]      <= 1'b1;
          slot_rw[i]   <= req_rw[i];
          slot_addr[i] <= req_addr[i*ADDR_W +: ADDR_W];
          slot_data[i] <= req_data[i*LINE_W +: LINE_W];
        end else if (req_valid[i]) begin
          req_ovf[i] <= 1'b1;
        end else if (rsp_ready[i]) begin
          pend[i] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    state_nxt = state;
    mem_valid = 1'b0;
    mem_rw    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    rsp_ready = '0;
    rsp_data  = '0;
    case (state)
      IDLE: begin
        if (rr_any)
          state_nxt = ISSUE;
      end
      ISSUE: begin
        mem_valid = 1'b1;
        mem_rw    = slot_rw[owner];
        mem_addr  = slot_addr[owner];
        mem_wdata = slot_data[owner];
        state_nxt = WAIT;
      end
      WAIT: begin
        mem_rw    = slot_rw[owner];
        mem_addr  = slot_addr[owner];
        mem_wdata = slot_data[owner];
        if (mem_ready) begin
          rsp_ready[owner] = 1'b1;
          rsp_data         = mem_rdata;
          state_nxt        = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter with two ports: latency, round-robin
// order, same-edge refill, overflow, fairness and mid-transaction reset.
module tb_cache_mem_arbiter;

  logic         clk;
  logic         rst;
  logic [1:0]   req_valid;
  logic [1:0]   req_rw;
  logic [63:0]  req_addr;
  logic [255:0] req_data;
  logic [1:0]   rsp_ready;
  logic [127:0] rsp_data;
  logic [1:0]   req_ovf;
  logic         mem_valid;
  logic         mem_rw;
  logic [31:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic         mem_ready;
  logic [127:0] mem_rdata;

  int assertions_evaluated = 0;
  int failures = 0;

  localparam logic [127:0] RD_A5 = {16{8'hA5}};
  localparam logic [127:0] RD_2  = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
  localparam logic [127:0] WR_1  = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
  localparam logic [127:0] WR_3  = 128'hDEAD_BEEF_CAFE_F00D_1234_5678_9ABC_DEF0;

  cache_mem_arbiter #(
    .NUM_PORTS (2),
    .ADDR_W    (32),
    .LINE_W    (128)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_rw    (req_rw),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .req_ovf   (req_ovf),
    .mem_valid (mem_valid),
    .mem_rw    (mem_rw),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    assertions_evaluated++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  // Advance one cycle; pulse inputs drop right after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    req_valid = '0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] valid, input logic [1:0] rw,
                               input logic [31:0] a0, input logic [31:0] a1,
                               input logic [127:0] d0, input logic [127:0] d1);
    req_valid = valid;
    req_rw    = rw;
    req_addr  = {a1, a0};
    req_data  = {d1, d0};
    #1;
  endtask

  task automatic respond(input logic [127:0] rdata);
    mem_ready = 1'b1;
    mem_rdata = rdata;
    #1;
  endtask

  task automatic resetDut(input string tag);
    rst = 1'b1;
    tick();
    tick();
    checkOutput({tag, "_rst_mem_valid"}, mem_valid, 0);
    checkOutput({tag, "_rst_mem_addr"}, mem_addr, 0);
    checkOutput({tag, "_rst_rsp_ready"}, rsp_ready, 0);
    checkOutput({tag, "_rst_ovf"}, req_ovf, 0);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_rw = '0;
    req_addr = '0;
    req_data = '0;
    mem_ready = 1'b0;
    mem_rdata = '0;

    // Single read on port 0: mem_valid two cycles after the pulse.
    resetDut("s1");
    applyStimulus(2'b01, 2'b00, 32'h0000_1230, 32'h0, '0, '0);
    tick();
    checkOutput("s1_no_early_valid", mem_valid, 0);
    tick();
    checkOutput("s1_mem_valid", mem_valid, 1);
    checkOutput("s1_mem_rw", mem_rw, 0);
    checkOutput("s1_mem_addr", mem_addr, 32'h0000_1230);
    tick();
    checkOutput("s1_valid_one_cycle", mem_valid, 0);
    checkOutput("s1_addr_held", mem_addr, 32'h0000_1230);
    tick();
    tick();
    respond(RD_A5);
    checkOutput("s1_rsp_ready", rsp_ready, 2'b01);
    checkOutput("s1_rsp_data", rsp_data, RD_A5);
    tick();
    checkOutput("s1_rsp_idle", rsp_ready, 0);
    checkOutput("s1_rsp_data_idle", rsp_data, 0);
    checkOutput("s1_addr_idle", mem_addr, 0);

    // Simultaneous requests: port 0 first, port 1 two cycles after the response.
    resetDut("s2");
    applyStimulus(2'b11, 2'b10, 32'h100, 32'h200, '0, WR_1);
    tick();
    tick();
    checkOutput("s2_p0_valid", mem_valid, 1);
    checkOutput("s2_p0_addr", mem_addr, 32'h100);
    checkOutput("s2_p0_rw", mem_rw, 0);
    tick();
    respond(RD_2);
    checkOutput("s2_p0_rsp", rsp_ready, 2'b01);
    checkOutput("s2_p0_rdata", rsp_data, RD_2);
    tick();
    checkOutput("s2_gap", mem_valid, 0);
    tick();
    checkOutput("s2_p1_valid", mem_valid, 1);
    checkOutput("s2_p1_addr", mem_addr, 32'h200);
    checkOutput("s2_p1_rw", mem_rw, 1);
    checkOutput("s2_p1_wdata", mem_wdata, WR_1);
    tick();
    respond('0);
    checkOutput("s2_p1_rsp", rsp_ready, 2'b10);

    // Write-back then fill on port 1, the fill arriving in the rsp_ready cycle.
    tick();
    applyStimulus(2'b10, 2'b10, 32'h0, 32'h4000, '0, WR_3);
    tick();
    tick();
    checkOutput("s3_wb_valid", mem_valid, 1);
    checkOutput("s3_wb_addr", mem_addr, 32'h4000);
    checkOutput("s3_wb_rw", mem_rw, 1);
    tick();
    mem_ready = 1'b1;
    mem_rdata = '0;
    applyStimulus(2'b10, 2'b00, 32'h0, 32'h8000, '0, '0);
    checkOutput("s3_wb_rsp", rsp_ready, 2'b10);
    tick();
    checkOutput("s3_no_ovf", req_ovf, 0);
    checkOutput("s3_gap", mem_valid, 0);
    tick();
    checkOutput("s3_fill_valid", mem_valid, 1);
    checkOutput("s3_fill_addr", mem_addr, 32'h8000);
    checkOutput("s3_fill_rw", mem_rw, 0);
    tick();
    respond(RD_A5);
    checkOutput("s3_fill_rsp", rsp_ready, 2'b10);

    // Overflow: second pulse on a busy port 0 is dropped and flagged.
    tick();
    applyStimulus(2'b01, 2'b00, 32'h300, 32'h0, '0, '0);
    tick();
    applyStimulus(2'b01, 2'b00, 32'h380, 32'h0, '0, '0);
    tick();
    checkOutput("s4_ovf_set", req_ovf, 2'b01);
    checkOutput("s4_first_valid", mem_valid, 1);
    checkOutput("s4_first_addr", mem_addr, 32'h300);
    tick();
    respond(RD_2);
    checkOutput("s4_first_rsp", rsp_ready, 2'b01);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("s4_no_second_issue", mem_valid, 0);
    end
    checkOutput("s4_ovf_sticky", req_ovf, 2'b01);

    // Fairness: port 0 re-requests on its completion while port 1 waits.
    resetDut("s5");
    applyStimulus(2'b11, 2'b00, 32'h500, 32'h600, '0, '0);
    tick();
    tick();
    checkOutput("s5_p0_addr", mem_addr, 32'h500);
    tick();
    mem_ready = 1'b1;
    mem_rdata = RD_A5;
    applyStimulus(2'b01, 2'b00, 32'h510, 32'h0, '0, '0);
    checkOutput("s5_p0_rsp", rsp_ready, 2'b01);
    tick();
    tick();
    checkOutput("s5_p1_valid", mem_valid, 1);
    checkOutput("s5_p1_addr", mem_addr, 32'h600);
    tick();
    respond(RD_2);
    checkOutput("s5_p1_rsp", rsp_ready, 2'b10);
    tick();
    tick();
    checkOutput("s5_p0_again_addr", mem_addr, 32'h510);
    tick();
    respond('0);
    checkOutput("s5_p0_again_rsp", rsp_ready, 2'b01);
    checkOutput("s5_no_ovf", req_ovf, 0);

    // Reset while waiting on memory: the in-flight response is discarded.
    tick();
    applyStimulus(2'b01, 2'b00, 32'h700, 32'h0, '0, '0);
    tick();
    tick();
    checkOutput("s6_issue_addr", mem_addr, 32'h700);
    tick();
    rst = 1'b1;
    #1;
    tick();
    rst = 1'b0;
    checkOutput("s6_rst_valid", mem_valid, 0);
    checkOutput("s6_rst_addr", mem_addr, 0);
    respond(RD_A5);
    checkOutput("s6_late_rsp", rsp_ready, 0);
    checkOutput("s6_late_rdata", rsp_data, 0);
    tick();
    applyStimulus(2'b10, 2'b00, 32'h0, 32'h900, '0, '0);
    checkOutput("s6_pend_cleared", mem_valid, 0);
    tick();
    checkOutput("s6_gap", mem_valid, 0);
    tick();
    checkOutput("s6_p1_valid", mem_valid, 1);
    checkOutput("s6_p1_addr", mem_addr, 32'h900);
    tick();
    respond(RD_2);
    checkOutput("s6_p1_rsp", rsp_ready, 2'b10);
    checkOutput("s6_p1_rdata", rsp_data, RD_2);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             assertions_evaluated, failures);
    $finish;
  end

endmodule
